cmd_receptor_stp: RTL
=====================

// Module: cmd_receptor_stp
// PURPOSE
//  Serial-to-parallel receiver for CMD-line responses. Sits between the CMD pad (input mode) and
//  control_capa_fisica: hunts for a start bit, shifts in the payload, optionally checks CRC7,
//  checks the end bit, then presents pad_response with reception_complete.
//  Response timeout stays in the controller.
// PARAMETERS
//  DATA_W  15  payload bits between start bit and CRC/end bit, MSB first
//  CRC_EN  0   1: 7 CRC bits follow the payload and are checked; 0: end bit follows the payload
// PORTS
//  sd_clock            in   1       SD card clock; all sampling on posedge
//  reset               in   1       asynchronous, active-low reset
//  reset_wrapper       in   1       synchronous clear from controller, active-high
//  enable_stp_wrapper  in   1       level; 1 = receive a frame
//  cmd_in              in   1       serial CMD line from pad
//  pad_response        out  DATA_W  last received payload
//  reception_complete  out  1       frame finished; held until cleared
//  framing_error       out  1       end bit sampled as 0
//  crc_error           out  1       CRC7 mismatch (CRC_EN=1 only, else tied 0)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE. pad_response=0, reception_complete=0, framing_error=0,
//   crc_error=0. Shift register, bit counter and CRC are cleared.
//  reset_wrapper=1: same clear as reset, on the next posedge. Priority: reset > reset_wrapper > enable.
//  States:
//   IDLE:  enable=1 -> HUNT.
//   HUNT:  cmd_in=0 -> SHIFT with cnt=0 and CRC seeded with the start bit; cmd_in=1 -> stay.
//   SHIFT: each cycle shreg <= {shreg[DATA_W-2:0], cmd_in} and CRC updated.
//          cnt==DATA_W-1 -> CRC (CRC_EN=1) or STOP (CRC_EN=0).
//   CRC:   shift 7 received bits into rx_crc; after the 7th bit -> STOP.
//   STOP:  sample end bit; framing_error <= ~cmd_in; crc_error <= CRC_EN & (rx_crc != calc_crc);
//          pad_response <= shreg; -> DONE.
//   DONE:  reception_complete=1; hold all outputs until reset_wrapper, then -> IDLE.
//  Latency (CRC_EN=0): start bit sampled at edge N; payload at N+1..N+DATA_W; end bit at
//   N+DATA_W+1; reception_complete high after edge N+DATA_W+2 (registered). CRC_EN=1 adds 7 cycles.
//  CRC7: poly x^7+x^3+1, init 0, computed over start bit + payload, MSB first.
//  Boundaries:
//   - enable falls mid-frame (HUNT/SHIFT/CRC/STOP) -> IDLE, partial data discarded,
//     pad_response keeps the last completed frame, no flags set.
//   - Bad end bit: frame still completes (reception_complete=1) so the controller never waits
//     on a malformed frame; framing_error flags it.
//   - enable falls in DONE: outputs held; only reset_wrapper/reset clears.
//   - reset_wrapper and start bit on the same edge: clear wins, start bit ignored.
//   - Back-to-back frames require reset_wrapper between them.
//   - pad_response changes only on the STOP->DONE edge.
// STRUCTURE
//  Package sd_cmd_pkg: state localparams (one-hot, 6 bits), CRC7_POLY=7'h09, START_BIT=1'b0,
//   END_BIT=1'b1.
//  Sub-module sd_crc7 (serial CRC7: clr, en, din -> crc[6:0]), instantiated here and reusable
//   by the P-S wrapper.
//  Top: FSM + bit counter ($clog2(DATA_W) bits) + shift register + output registers.
// TESTING
//  1 DATA_W=15,CRC_EN=0: idle 1s, then 0,15'h5A3C MSB-first,1 -> pad_response=15'h5A3C,
//    reception_complete high at end-bit edge+1, both error flags 0.
//  2 Same frame with end bit 0 -> reception_complete=1, framing_error=1, pad_response=15'h5A3C.
//  3 DATA_W=39,CRC_EN=1: 0, 39'h40_0000_0000, CRC 7'h4A, 1 -> crc_error=0.
//    Repeat with CRC 7'h4B -> crc_error=1.
//  4 enable dropped after 8 payload bits -> IDLE, reception_complete=0,
//    pad_response unchanged from the previous frame.
//  5 reset pulled low mid-SHIFT (async, between edges) -> all outputs 0 immediately.
//    After release + enable, a full 15'h7FFF frame is received correctly.
//  6 In DONE assert reset_wrapper one cycle -> outputs cleared next edge;
//    a start bit on the same edge is ignored.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD-line serial receiver and transmitter:
// one-hot state encoding, CRC7 polynomial, frame delimiter bits and a
// single-step CRC7 helper.
package sd_cmd_pkg;

    // One-hot receiver states (6 bits, one per state)
    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_HUNT  = 6'b000010,
        ST_SHIFT = 6'b000100,
        ST_CRC   = 6'b001000,
        ST_STOP  = 6'b010000,
        ST_DONE  = 6'b100000
    } stp_state_t;

    // x^7 + x^3 + 1, with the x^7 term implicit
    localparam logic [6:0] CRC7_POLY = 7'h09;
    localparam logic       START_BIT = 1'b0;
    localparam logic       END_BIT   = 1'b1;
    localparam int         CRC_BITS  = 7;

    // Advance a CRC7 register by one serial bit, MSB first
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 generator (x^7 + x^3 + 1, init 0), one bit per enabled cycle.
// clr has priority over en so a frame can be restarted in the same cycle.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       sd_clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_reg;

    // CRC register: async clear, sync clear, then serial update
    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            crc_reg <= '0;
        end else if (clr) begin
            crc_reg <= '0;
        end else if (en) begin
            crc_reg <= crc7_step(crc_reg, din);
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/cmd_receptor_stp.sv
// Serial-to-parallel receiver for SD CMD-line responses.
// Hunts for the start bit, shifts in DATA_W payload bits MSB first,
// optionally captures and checks a trailing CRC7, samples the end bit and
// then holds the result with reception_complete until the controller clears
// it with reset_wrapper. Timeouts are handled by the controller.
module cmd_receptor_stp
    import sd_cmd_pkg::*;
#(
    parameter int DATA_W = 15,
    parameter int CRC_EN = 0
) (
    input  logic              sd_clock,
    input  logic              reset,
    input  logic              reset_wrapper,
    input  logic              enable_stp_wrapper,
    input  logic              cmd_in,
    output logic [DATA_W-1:0] pad_response,
    output logic              reception_complete,
    output logic              framing_error,
    output logic              crc_error
);

    // The counter is shared by payload and CRC phases, so it must reach 6 too
    localparam int CNT_W = ($clog2(DATA_W) < 3) ? 3 : $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST_CRC  = CNT_W'(CRC_BITS - 1);

    stp_state_t        state_reg;
    stp_state_t        state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] shreg_reg;
    logic [6:0]        rx_crc_reg;
    logic [DATA_W-1:0] pad_response_reg;
    logic              complete_reg;
    logic              framing_error_reg;
    logic              crc_error_reg;

    logic              crc_clr;
    logic              crc_en;
    logic [6:0]        calc_crc;

    // Running CRC over start bit + payload
    sd_crc7 u_crc7 (
        .sd_clock (sd_clock),
        .reset    (reset),
        .clr      (crc_clr),
        .en       (crc_en),
        .din      (cmd_in),
        .crc      (calc_crc)
    );

    // State register
    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and CRC control; a controller clear overrides everything,
    // and losing enable mid-frame abandons the frame (DONE is sticky)
    always_comb begin
        state_next = state_reg;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        if (reset_wrapper) begin
            state_next = ST_IDLE;
            crc_clr    = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    crc_clr = 1'b1;
                    if (enable_stp_wrapper) begin
                        state_next = ST_HUNT;
                    end
                end
                ST_HUNT: begin
                    if (!enable_stp_wrapper) begin
                        state_next = ST_IDLE;
                    end else if (cmd_in == START_BIT) begin
                        // Start bit seeds the CRC
                        crc_en     = 1'b1;
                        state_next = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!enable_stp_wrapper) begin
                        state_next = ST_IDLE;
                    end else begin
                        crc_en = 1'b1;
                        if (cnt_reg == CNT_LAST_DATA) begin
                            state_next = (CRC_EN != 0) ? ST_CRC : ST_STOP;
                        end
                    end
                end
                ST_CRC: begin
                    if (!enable_stp_wrapper) begin
                        state_next = ST_IDLE;
                    end else if (cnt_reg == CNT_LAST_CRC) begin
                        state_next = ST_STOP;
                    end
                end
                ST_STOP: begin
                    state_next = enable_stp_wrapper ? ST_DONE : ST_IDLE;
                end
                ST_DONE: begin
                    state_next = ST_DONE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: bit counter, shift registers and result/flag registers
    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            cnt_reg           <= '0;
            shreg_reg         <= '0;
            rx_crc_reg        <= '0;
            pad_response_reg  <= '0;
            complete_reg      <= 1'b0;
            framing_error_reg <= 1'b0;
            crc_error_reg     <= 1'b0;
        end else if (reset_wrapper) begin
            cnt_reg           <= '0;
            shreg_reg         <= '0;
            rx_crc_reg        <= '0;
            pad_response_reg  <= '0;
            complete_reg      <= 1'b0;
            framing_error_reg <= 1'b0;
            crc_error_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Discard any partially received frame
                    cnt_reg    <= '0;
                    shreg_reg  <= '0;
                    rx_crc_reg <= '0;
                end
                ST_HUNT: begin
                    cnt_reg <= '0;
                end
                ST_SHIFT: begin
                    if (enable_stp_wrapper) begin
                        shreg_reg <= {shreg_reg[DATA_W-2:0], cmd_in};
                        cnt_reg   <= (cnt_reg == CNT_LAST_DATA) ? '0 : cnt_reg + 1'b1;
                    end
                end
                ST_CRC: begin
                    if (enable_stp_wrapper) begin
                        rx_crc_reg <= {rx_crc_reg[5:0], cmd_in};
                        cnt_reg    <= cnt_reg + 1'b1;
                    end
                end
                ST_STOP: begin
                    // Results are published only when the frame is kept
                    if (enable_stp_wrapper) begin
                        pad_response_reg  <= shreg_reg;
                        framing_error_reg <= (cmd_in != END_BIT);
                        crc_error_reg     <= (CRC_EN != 0) && (rx_crc_reg != calc_crc);
                    end
                end
                ST_DONE: begin
                    complete_reg <= 1'b1;
                end
                default: begin
                    cnt_reg <= '0;
                end
            endcase
        end
    end

    assign pad_response       = pad_response_reg;
    assign reception_complete = complete_reg;
    assign framing_error      = framing_error_reg;
    assign crc_error          = crc_error_reg;

endmodule
